shreg_chain_driver: RTL and testbench

Parametrised serial driver for a daisy-chain of NUM_REGS 74HC595-style shift registers, the successor to the fixed 24-bit reg_write. It accepts a full chain word over a valid/ready handshake and shifts it out on d/sh_cp at a programmable rate, MSB- or LSB-first, then pulses st_cp. It also drives a PWM output-enable (oe_n) for display brightness. It sits between the decoder and the display pins.

---
 rtl/shreg_pkg.sv | 16 +
 rtl/shreg_chain_driver_pwm_dimmer.sv | 32 +++
 rtl/shreg_chain_driver.sv | 140 ++++++++++++++
 tb/tb_shreg_chain_driver.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shreg_pkg.sv
// Shared types and helpers for the 74HC595 chain driver.
package shreg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SH_LO,
        SH_HI,
        LATCH
    } state_t;

    // Clock cycles from the accept edge until ready is high again.
    function automatic int xfer_cycles(input int w, input int div);
        return (2 * w + 1) * div;
    endfunction

endpackage

// File: rtl/shreg_chain_driver_pwm_dimmer.sv
// PWM output-enable generator for display brightness.
module pwm_dimmer
    import shreg_pkg::*;
#(
    parameter int BRIGHT_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [BRIGHT_W-1:0] brightness,
    output logic                oe_n
);

    logic [BRIGHT_W-1:0] cnt;
    logic [BRIGHT_W-1:0] level;

    // The level is loaded as the counter wraps to 0, so each period
    // runs with a single duty value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= '0;
        end else begin
            cnt <= cnt + 1'b1;
            if (cnt == '1) begin
                level <= brightness;
            end
        end
    end

    assign oe_n = !((level == '1) || (cnt < level));

endmodule

// File: rtl/shreg_chain_driver.sv
// Serial driver for a daisy-chain of 74HC595 shift registers,
// with a PWM output enable for brightness.
module shreg_chain_driver
    import shreg_pkg::*;
#(
    parameter int NUM_REGS  = 3,
    parameter int SCK_DIV   = 2,
    parameter int MSB_FIRST = 1,
    parameter int BRIGHT_W  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [8*NUM_REGS-1:0]   data,
    input  logic                    d_valid,
    output logic                    ready,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic                    st_cp,
    output logic                    sh_cp,
    output logic                    d,
    output logic                    oe_n
);

    localparam int W  = 8 * NUM_REGS;
    localparam int CW = $clog2(W + 1);
    localparam int TW = $clog2(SCK_DIV + 1);
    localparam logic [CW-1:0] LAST_BIT  = CW'(W);
    localparam logic [TW-1:0] TIMER_END = TW'(SCK_DIV - 1);

    state_t        state;
    logic [W-1:0]  sreg;
    logic [W-1:0]  shifted;
    logic [CW-1:0] bit_cnt;
    logic [TW-1:0] timer;
    logic          phase_end;

    function automatic logic head(input logic [W-1:0] v);
        return (MSB_FIRST != 0) ? v[W-1] : v[0];
    endfunction

    assign ready     = (state == IDLE);
    assign phase_end = (timer == TIMER_END);

    always_comb begin
        shifted = sreg;
        if (MSB_FIRST != 0) begin
            shifted = {sreg[W-2:0], 1'b0};
        end else begin
            shifted = {1'b0, sreg[W-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sreg    <= '0;
            bit_cnt <= '0;
            timer   <= '0;
            sh_cp   <= 1'b0;
            st_cp   <= 1'b0;
            d       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (d_valid) begin
                        sreg    <= data;
                        bit_cnt <= '0;
                        timer   <= '0;
                        d       <= head(data);
                        state   <= SH_LO;
                    end
                end
                SH_LO: begin
                    if (phase_end) begin
                        timer <= '0;
                        sh_cp <= 1'b1;
                        state <= SH_HI;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                SH_HI: begin
                    if (phase_end) begin
                        timer   <= '0;
                        sh_cp   <= 1'b0;
                        sreg    <= shifted;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt + 1'b1 == LAST_BIT) begin
                            d     <= 1'b0;
                            st_cp <= 1'b1;
                            state <= LATCH;
                        end else begin
                            d     <= head(shifted);
                            state <= SH_LO;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                LATCH: begin
                    if (phase_end) begin
                        timer <= '0;
                        st_cp <= 1'b0;
                        state <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    pwm_dimmer #(
        .BRIGHT_W(BRIGHT_W)
    ) u_pwm (
        .clk        (clk),
        .rst_n      (rst_n),
        .brightness (brightness),
        .oe_n       (oe_n)
    );

`ifndef SYNTHESIS
    localparam int XFER = xfer_cycles(W, SCK_DIV);
    int busy_cycles;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cycles <= 0;
        end else begin
            busy_cycles <= ready ? 0 : busy_cycles + 1;
            if (state == LATCH && phase_end) begin
                assert (busy_cycles == XFER - 1);
            end
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) !(st_cp && sh_cp));
`endif

endmodule

// File: tb/tb_shreg_chain_driver.sv
// Directed bench for shreg_chain_driver: three parameter sets,
// table-driven transfers plus reset, back-to-back and PWM sequences.
module tb_shreg_chain_driver;
    import shreg_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // DUT0: defaults (24 bits, SCK_DIV=2, MSB first)
    logic        rst0, v0, rdy0, st0, sh0, d0, oe0;
    logic [23:0] data0;
    logic [3:0]  br0;
    // DUT1: 8 bits, SCK_DIV=1, LSB first
    logic        rst1, v1, rdy1, st1, sh1, d1, oe1;
    logic [7:0]  data1;
    logic [3:0]  br1;
    // DUT2: 40 bits, SCK_DIV=3, MSB first
    logic        rst2, v2, rdy2, st2, sh2, d2, oe2;
    logic [39:0] data2;
    logic [3:0]  br2;

    shreg_chain_driver u0 (
        .clk(clk), .rst_n(rst0), .data(data0), .d_valid(v0),
        .ready(rdy0), .brightness(br0), .st_cp(st0), .sh_cp(sh0),
        .d(d0), .oe_n(oe0));

    shreg_chain_driver #(.NUM_REGS(1), .SCK_DIV(1), .MSB_FIRST(0)) u1 (
        .clk(clk), .rst_n(rst1), .data(data1), .d_valid(v1),
        .ready(rdy1), .brightness(br1), .st_cp(st1), .sh_cp(sh1),
        .d(d1), .oe_n(oe1));

    shreg_chain_driver #(.NUM_REGS(5), .SCK_DIV(3)) u2 (
        .clk(clk), .rst_n(rst2), .data(data2), .d_valid(v2),
        .ready(rdy2), .brightness(br2), .st_cp(st2), .sh_cp(sh2),
        .d(d2), .oe_n(oe2));

    // Monitors: record d at every sh_cp rise, count st_cp high cycles.
    bit q0[$];
    bit q1[$];
    bit q2[$];
    int stc0 = 0, stc1 = 0, stc2 = 0, both = 0;
    logic shp0 = 1'b0, shp1 = 1'b0, shp2 = 1'b0;

    always @(negedge clk) begin
        if (sh0 && !shp0) q0.push_back(d0);
        if (sh1 && !shp1) q1.push_back(d1);
        if (sh2 && !shp2) q2.push_back(d2);
        if (st0) stc0++;
        if (st1) stc1++;
        if (st2) stc2++;
        if ((st0 && sh0) || (st1 && sh1) || (st2 && sh2)) both++;
        shp0 = sh0;
        shp1 = sh1;
        shp2 = sh2;
    end

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic rdy(input int k);
        case (k)
            0: return rdy0;
            1: return rdy1;
            default: return rdy2;
        endcase
    endfunction

    function automatic int nb(input int k);
        case (k)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic int stc(input int k);
        case (k)
            0: return stc0;
            1: return stc1;
            default: return stc2;
        endcase
    endfunction

    function automatic bit bitat(input int k, input int i);
        if (i >= nb(k)) return 1'b0;
        case (k)
            0: return q0[i];
            1: return q1[i];
            default: return q2[i];
        endcase
    endfunction

    task automatic drive(input int k, input logic [63:0] w, input logic v);
        case (k)
            0: begin data0 = w[23:0]; v0 = v; end
            1: begin data1 = w[7:0];  v1 = v; end
            default: begin data2 = w[39:0]; v2 = v; end
        endcase
    endtask

    function automatic logic [63:0] word_at(input int k, input int n0,
                                            input int wbits);
        logic [63:0] got;
        got = '0;
        for (int j = 0; j < wbits; j++) got = {got[62:0], bitat(k, n0 + j)};
        return got;
    endfunction

    // One transfer: accept, then check latency, bit count, order, latch pulse.
    task automatic xfer(input int k, input logic [63:0] w, input int wbits,
                        input int div, input logic [63:0] exp_seq,
                        input int exp_lat, input string nm);
        int n0, s0, lat, g;
        g = 0;
        @(negedge clk);
        while (!rdy(k) && g < 1000) begin
            @(negedge clk);
            g++;
        end
        n0 = nb(k);
        s0 = stc(k);
        drive(k, w, 1'b1);
        @(posedge clk);
        #1 drive(k, ~w, 1'b0);
        lat = 0;
        while (!rdy(k) && lat < 1000) begin
            @(posedge clk);
            #1 lat++;
        end
        @(negedge clk);
        #1;
        check({nm, " latency"}, 64'(lat), 64'(exp_lat));
        check({nm, " sh_cp rises"}, 64'(nb(k) - n0), 64'(wbits));
        check({nm, " d order"}, word_at(k, n0, wbits), exp_seq);
        check({nm, " st_cp cycles"}, 64'(stc(k) - s0), 64'(div));
    endtask

    typedef struct {
        logic [63:0] data;
        logic [63:0] seq;
        int          lat;
    } vec_t;

    vec_t t0[4];
    vec_t t1[3];

    function automatic logic [23:0] bb_word(input int i);
        return 24'h5A3C00 + 24'(i) * 24'h009D13;
    endfunction

    initial begin
        int n0, s0, g, lows, found;
        logic prev;
        logic [63:0] w;

        t0[0] = '{64'hA53C0F, 64'b1010_0101_0011_1100_0000_1111, 98};
        t0[1] = '{64'hFFFFFF, 64'hFFFFFF, 98};
        t0[2] = '{64'h000000, 64'h000000, 98};
        t0[3] = '{64'h800001, 64'b1000_0000_0000_0000_0000_0001, 98};
        t1[0] = '{64'h01, 64'b1000_0000, 17};
        t1[1] = '{64'hC4, 64'b0010_0011, 17};
        t1[2] = '{64'h80, 64'b0000_0001, 17};

        rst0 = 0; rst1 = 0; rst2 = 0;
        v0 = 0; v1 = 0; v2 = 0;
        data0 = '0; data1 = '0; data2 = '0;
        br0 = 4'd0; br1 = 4'd0; br2 = 4'd0;
        #1;
        check("reset ready", 64'(rdy0), 64'd1);
        check("reset st_cp", 64'(st0), 64'd0);
        check("reset sh_cp", 64'(sh0), 64'd0);
        check("reset d", 64'(d0), 64'd0);
        check("reset oe_n", 64'(oe0), 64'd1);
        repeat (3) @(negedge clk);
        rst0 = 1; rst1 = 1; rst2 = 1;
        br0 = 4'd15;

        for (int i = 0; i < 4; i++)
            xfer(0, t0[i].data, 24, 2, t0[i].seq, t0[i].lat, "dut0");
        for (int i = 0; i < 3; i++)
            xfer(1, t1[i].data, 8, 1, t1[i].seq, t1[i].lat, "dut1");
        for (int i = 0; i < 2; i++) begin
            w = {24'($urandom), 32'($urandom)} & 64'hFF_FFFF_FFFF;
            xfer(2, w, 40, 3, w, 243, "dut2");
        end

        // d_valid held high, data changing every cycle
        @(negedge clk);
        n0 = nb(0);
        s0 = stc(0);
        for (int i = 0; i < 297; i++) begin
            data0 = bb_word(i);
            v0 = 1'b1;
            @(negedge clk);
        end
        v0 = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        check("b2b rises", 64'(nb(0) - n0), 64'd72);
        check("b2b st_cp", 64'(stc(0) - s0), 64'd6);
        check("b2b ready", 64'(rdy0), 64'd1);
        check("b2b word0", word_at(0, n0, 24), 64'(bb_word(0)));
        check("b2b word1", word_at(0, n0 + 24, 24), 64'(bb_word(99)));
        check("b2b word2", word_at(0, n0 + 48, 24), 64'(bb_word(198)));

        // Reset after the 10th sh_cp rise
        check("oe full on", 64'(oe0), 64'd0);
        n0 = nb(0);
        s0 = stc(0);
        drive(0, 64'hFFFFFF, 1'b1);
        @(posedge clk);
        #1 drive(0, 64'h0, 1'b0);
        g = 0;
        while (nb(0) - n0 < 10 && g < 500) begin
            @(negedge clk);
            #1 g++;
        end
        check("pre-reset sh_cp", 64'(sh0), 64'd1);
        rst0 = 1'b0;
        #1;
        check("async st_cp", 64'(st0), 64'd0);
        check("async sh_cp", 64'(sh0), 64'd0);
        check("async d", 64'(d0), 64'd0);
        check("async oe_n", 64'(oe0), 64'd1);
        check("async ready", 64'(rdy0), 64'd1);
        repeat (4) @(negedge clk);
        rst0 = 1'b1;
        check("no latch on reset", 64'(stc(0) - s0), 64'd0);
        xfer(0, 64'hA53C0F, 24, 2, 64'hA53C0F, 98, "post-reset");

        // PWM
        br0 = 4'd4;
        repeat (40) @(negedge clk);
        lows = 0;
        repeat (16) begin
            @(negedge clk);
            #1 if (!oe0) lows++;
        end
        check("pwm 4/16", 64'(lows), 64'd4);

        found = 0;
        prev = oe0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (!oe0 && prev) begin
                found = 1;
                break;
            end
            prev = oe0;
        end
        check("pwm phase found", 64'(found), 64'd1);
        repeat (6) @(negedge clk);
        #1 br0 = 4'd12;
        lows = 0;
        repeat (9) begin
            @(negedge clk);
            #1 if (!oe0) lows++;
        end
        check("pwm old duty kept", 64'(lows), 64'd0);
        lows = 0;
        repeat (16) begin
            @(negedge clk);
            #1 if (!oe0) lows++;
        end
        check("pwm 12/16", 64'(lows), 64'd12);

        br0 = 4'd0;
        repeat (40) @(negedge clk);
        lows = 0;
        repeat (16) begin
            @(negedge clk);
            #1 if (!oe0) lows++;
        end
        check("pwm dark", 64'(lows), 64'd0);

        br0 = 4'd15;
        repeat (40) @(negedge clk);
        lows = 0;
        repeat (16) begin
            @(negedge clk);
            #1 if (!oe0) lows++;
        end
        check("pwm full", 64'(lows), 64'd16);

        check("st_cp and sh_cp overlap", 64'(both), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
